// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet source/sink pair.
// State encoding and default widths.
package axis_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } axis_state_e;

  localparam int AXIS_WIDTH     = 8;
  localparam int AXIS_LEN_WIDTH = 16;
  localparam int AXIS_CNT_WIDTH = 16;

endpackage

// File: rtl/axis_packet_source.sv
// AXI-Stream packet generator: one framed packet per start,
// incrementing data from seed, tlast on the final beat.
module axis_packet_source
  import axis_pkg::*;
#(
  parameter int c_WIDTH     = AXIS_WIDTH,
  parameter int c_LEN_WIDTH = AXIS_LEN_WIDTH,
  parameter int c_CNT_WIDTH = AXIS_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [c_LEN_WIDTH-1:0] len,
  input  logic [c_WIDTH-1:0]     seed,
  output logic                   busy,
  output logic                   done,
  output logic [c_CNT_WIDTH-1:0] pkt_count,
  output logic [c_WIDTH-1:0]     m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);

  axis_state_e            state_q;
  logic [c_LEN_WIDTH-1:0] left_q;
  logic [c_WIDTH-1:0]     data_q;
  logic                   valid_q;
  logic                   last_q;
  logic                   busy_q;
  logic                   done_q;
  logic [c_CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && len != '0) begin
            left_q  <= len;
            data_q  <= seed;
            valid_q <= 1'b1;
            last_q  <= (len == c_LEN_WIDTH'(1));
            busy_q  <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (valid_q && m_axis_tready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= cnt_q + 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              data_q <= data_q + 1'b1;
              left_q <= left_q - 1'b1;
              // left_q still counts the beat just accepted
              last_q <= (left_q == c_LEN_WIDTH'(2));
            end
          end
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_count     = cnt_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = last_q;

endmodule

// File: tb/tb_axis_packet_source.sv
// Directed bench for axis_packet_source.
// Hand-computed expectations checked with immediate assertions.
module tb_axis_packet_source;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic [7:0]  seed;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  int n_run;
  int n_fail;
  int hs;

  axis_packet_source dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .len          (len),
    .seed         (seed),
    .busy         (busy),
    .done         (done),
    .pkt_count    (pkt_count),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d4 [4];
    logic [7:0] bp_d [6];
    logic       bp_v [6];
    logic       bp_l [6];
    logic       bp_r [6];
    n_run  = 0;
    n_fail = 0;
    hs     = 0;
    rst    = 1'b0;
    start  = 1'b0;
    len    = '0;
    seed   = '0;
    tready = 1'b0;
    #3;
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cnt", 32'(pkt_count), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // single beat
    start = 1; len = 1; seed = 8'h5A; tready = 1;
    tick();
    start = 0;
    chk("t1_valid", 32'(tvalid), 1);
    chk("t1_data", 32'(tdata), 32'h5A);
    chk("t1_last", 32'(tlast), 1);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_valid_off", 32'(tvalid), 0);
    chk("t1_done", 32'(done), 1);
    chk("t1_cnt", 32'(pkt_count), 1);
    chk("t1_idle", 32'(busy), 0);
    tick();
    chk("t1_done_off", 32'(done), 0);

    // four beats with wrap
    d4[0] = 8'hFE; d4[1] = 8'hFF; d4[2] = 8'h00; d4[3] = 8'h01;
    start = 1; len = 4; seed = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      tick();
      start = 0;
      chk("t2_valid", 32'(tvalid), 1);
      chk("t2_data", 32'(tdata), 32'(d4[i]));
      chk("t2_last", 32'(tlast), (i == 3) ? 1 : 0);
    end
    tick();
    chk("t2_valid_off", 32'(tvalid), 0);
    chk("t2_done", 32'(done), 1);
    chk("t2_cnt", 32'(pkt_count), 2);

    // backpressure with a start pulse while in flight
    bp_r[0] = 0; bp_r[1] = 1; bp_r[2] = 0;
    bp_r[3] = 0; bp_r[4] = 1; bp_r[5] = 1;
    bp_d[0] = 8'h10; bp_d[1] = 8'h11; bp_d[2] = 8'h11;
    bp_d[3] = 8'h11; bp_d[4] = 8'h12; bp_d[5] = 8'h00;
    bp_v[0] = 1; bp_v[1] = 1; bp_v[2] = 1;
    bp_v[3] = 1; bp_v[4] = 1; bp_v[5] = 0;
    bp_l[0] = 0; bp_l[1] = 0; bp_l[2] = 0;
    bp_l[3] = 0; bp_l[4] = 1; bp_l[5] = 0;
    tready = 0;
    start = 1; len = 3; seed = 8'h10;
    tick();
    start = 0;
    chk("t3_first", 32'(tdata), 32'h10);
    for (int i = 0; i < 6; i++) begin
      tready = bp_r[i];
      start  = (i == 2);
      len    = 5;
      seed   = 8'hAA;
      if (tvalid && tready) hs++;
      tick();
      chk("t3_valid", 32'(tvalid), 32'(bp_v[i]));
      chk("t3_last", 32'(tlast), 32'(bp_l[i]));
      if (i < 5) chk("t3_data", 32'(tdata), 32'(bp_d[i]));
    end
    start = 0;
    chk("t3_hs", 32'(hs), 3);
    chk("t3_done", 32'(done), 1);
    chk("t3_cnt", 32'(pkt_count), 3);
    tick();
    chk("t3_no_extra", 32'(tvalid), 0);

    // zero length is ignored
    start = 1; len = 0; seed = 8'h33;
    tick();
    start = 0;
    chk("t4_valid", 32'(tvalid), 0);
    chk("t4_busy", 32'(busy), 0);
    tick();
    chk("t4_done", 32'(done), 0);
    chk("t4_cnt", 32'(pkt_count), 3);

    // back-to-back
    tready = 1;
    start = 1; len = 2; seed = 8'h20;
    tick();
    start = 0;
    chk("t5_a0", 32'(tdata), 32'h20);
    tick();
    chk("t5_a1", 32'(tdata), 32'h21);
    chk("t5_a1_last", 32'(tlast), 1);
    tick();
    chk("t5_done_a", 32'(done), 1);
    chk("t5_cnt_a", 32'(pkt_count), 4);
    start = 1; len = 2; seed = 8'h30;
    tick();
    start = 0;
    chk("t5_b0_valid", 32'(tvalid), 1);
    chk("t5_b0", 32'(tdata), 32'h30);
    chk("t5_b0_done", 32'(done), 0);
    tick();
    chk("t5_b1", 32'(tdata), 32'h31);
    tick();
    chk("t5_done_b", 32'(done), 1);
    chk("t5_cnt_b", 32'(pkt_count), 5);

    // reset during beat 2 of 5
    start = 1; len = 5; seed = 8'h40;
    tick();
    start = 0;
    chk("t6_b1", 32'(tdata), 32'h40);
    tick();
    chk("t6_b2", 32'(tdata), 32'h41);
    #2;
    rst = 0;
    #1;
    chk("t6_valid", 32'(tvalid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cnt", 32'(pkt_count), 0);
    chk("t6_done", 32'(done), 0);
    @(negedge clk);
    rst = 1;
    start = 1; len = 2; seed = 8'h77;
    tick();
    start = 0;
    chk("t6_new_valid", 32'(tvalid), 1);
    chk("t6_new_data", 32'(tdata), 32'h77);
    tick();
    chk("t6_new_b2", 32'(tdata), 32'h78);
    tick();
    chk("t6_new_done", 32'(done), 1);
    chk("t6_new_cnt", 32'(pkt_count), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
